// File: rtl/bpu_pkg.sv
// Shared types and saturating-counter helper for the branch-predictor PHT controller.
package bpu_pkg;

  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    UPD_WR = 2'd2
  } state_t;

  localparam ctr_t CTR_MAX = 2'b11;
  localparam ctr_t CTR_MIN = 2'b00;

  function automatic ctr_t sat_upd(input ctr_t ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    else       return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Update FIFO holding {idx, taken} training requests; DEPTH must be a power of two.
module bpu_upd_fifo #(
  parameter int unsigned IDX_W = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [IDX_W-1:0] i_push_idx,
  input  logic             i_push_taken,
  input  logic             i_pop,
  output logic [IDX_W-1:0] o_head_idx,
  output logic             o_head_taken,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] r_idx   [DEPTH];
  logic             r_taken [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_idx   = r_idx[r_rd_ptr];
  assign o_head_taken = r_taken[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_idx[r_wr_ptr]   <= i_push_idx;
      r_taken[r_wr_ptr] <= i_push_taken;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bpu_table_ctrl.sv
// PHT port controller: init sweep, lookup/update arbitration and saturating RMW.
// Optional BPU_PERF_CNT_EN adds lookup/update/stall counters (tied to 0 otherwise).
module bpu_table_ctrl
  import bpu_pkg::*;
#(
  parameter int unsigned IDX_W    = 9,
  parameter int unsigned FIFO_D   = 4,
  parameter ctr_t        INIT_VAL = 2'b01
) (
  input  logic             in_Clk,
  input  logic             in_Rst_N,
  input  logic             in_lookup_valid,
  input  logic [IDX_W-1:0] in_lookup_idx,
  output logic             out_lookup_rdy,
  output logic             out_resp_valid,
  output logic [1:0]       out_resp_ctr,
  input  logic             in_upd_valid,
  input  logic [IDX_W-1:0] in_upd_idx,
  input  logic             in_upd_taken,
  output logic             out_upd_rdy,
  output logic             out_tbl_en,
  output logic             out_tbl_we,
  output logic [IDX_W-1:0] out_tbl_addr,
  output logic [1:0]       out_tbl_wdata,
  input  logic [1:0]       in_tbl_rdata,
  output logic             out_init_busy,
  output logic [31:0]      out_perf_lookups,
  output logic [31:0]      out_perf_updates,
  output logic [31:0]      out_perf_stalls
);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_init_busy;
  logic             r_resp_valid;
  ctr_t             r_resp_hold;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_taken;
  logic             w_accept;
  logic             w_en;
  logic             w_we;
  logic [IDX_W-1:0] w_addr;
  ctr_t             w_wdata;

  bpu_upd_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .i_clk        (in_Clk),
    .i_rst_n      (in_Rst_N),
    .i_push       (in_upd_valid),
    .i_push_idx   (in_upd_idx),
    .i_push_taken (in_upd_taken),
    .i_pop        (r_state == UPD_WR),
    .o_head_idx   (w_head_idx),
    .o_head_taken (w_head_taken),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty)
  );

  assign w_accept       = in_Rst_N && (r_state == IDLE) && !w_fifo_full && in_lookup_valid;
  assign out_lookup_rdy = w_accept;
  assign out_upd_rdy    = !w_fifo_full;
  assign out_resp_valid = r_resp_valid;
  assign out_init_busy  = r_init_busy;
  // Read data only exists in the response cycle, so it is passed through then and held after.
  assign out_resp_ctr   = r_resp_valid ? in_tbl_rdata : r_resp_hold;

  always_comb begin
    w_en    = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      INIT: begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_ptr;
        w_wdata = INIT_VAL;
      end
      IDLE: begin
        if (w_fifo_full) begin
          w_en   = 1'b1;
          w_addr = w_head_idx;
        end else if (in_lookup_valid) begin
          w_en   = 1'b1;
          w_addr = in_lookup_idx;
        end else if (!w_fifo_empty) begin
          w_en   = 1'b1;
          w_addr = w_head_idx;
        end
      end
      UPD_WR: begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_addr  = w_head_idx;
        w_wdata = sat_upd(in_tbl_rdata, w_head_taken);
      end
      default: ;
    endcase
  end

  assign out_tbl_en    = in_Rst_N && w_en;
  assign out_tbl_we    = in_Rst_N && w_we;
  assign out_tbl_addr  = w_addr;
  assign out_tbl_wdata = w_wdata;

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      r_state      <= INIT;
      r_ptr        <= '0;
      r_init_busy  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_hold  <= '0;
    end else begin
      r_resp_valid <= w_accept;
      if (r_resp_valid) r_resp_hold <= in_tbl_rdata;
      case (r_state)
        INIT: begin
          r_ptr <= r_ptr + IDX_W'(1);
          if (r_ptr == '1) begin
            r_state     <= IDLE;
            r_init_busy <= 1'b0;
          end
        end
        IDLE: begin
          if (w_fifo_full || (!in_lookup_valid && !w_fifo_empty)) r_state <= UPD_WR;
        end
        UPD_WR:  r_state <= IDLE;
        default: r_state <= INIT;
      endcase
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] r_perf_lookups;
  logic [31:0] r_perf_updates;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      r_perf_lookups <= '0;
      r_perf_updates <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_accept)                                            r_perf_lookups <= r_perf_lookups + 32'd1;
      if (r_state == UPD_WR)                                   r_perf_updates <= r_perf_updates + 32'd1;
      if (in_lookup_valid && !w_accept && (r_state != INIT))   r_perf_stalls  <= r_perf_stalls + 32'd1;
    end
  end

  assign out_perf_lookups = r_perf_lookups;
  assign out_perf_updates = r_perf_updates;
  assign out_perf_stalls  = r_perf_stalls;
`else
  assign out_perf_lookups = '0;
  assign out_perf_updates = '0;
  assign out_perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_bpu_table_ctrl.sv
// Scoreboard bench for bpu_table_ctrl with a behavioural 1-cycle SRAM and table model.
module tb_bpu_table_ctrl;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned FIFO_D = 4;
  localparam int unsigned N      = 16;
  localparam int unsigned DRAIN  = 2 * FIFO_D + 4;
  localparam int unsigned BOUND  = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_rdy;
  logic             resp_valid;
  logic [1:0]       resp_ctr;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_rdy;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;
  logic             init_busy;
  logic [31:0]      perf_lookups;
  logic [31:0]      perf_updates;
  logic [31:0]      perf_stalls;

  always #5 clk = ~clk;

  bpu_table_ctrl #(
    .IDX_W    (IDX_W),
    .FIFO_D   (FIFO_D),
    .INIT_VAL (2'b01)
  ) dut (
    .in_Clk           (clk),
    .in_Rst_N         (rst_n),
    .in_lookup_valid  (lookup_valid),
    .in_lookup_idx    (lookup_idx),
    .out_lookup_rdy   (lookup_rdy),
    .out_resp_valid   (resp_valid),
    .out_resp_ctr     (resp_ctr),
    .in_upd_valid     (upd_valid),
    .in_upd_idx       (upd_idx),
    .in_upd_taken     (upd_taken),
    .out_upd_rdy      (upd_rdy),
    .out_tbl_en       (tbl_en),
    .out_tbl_we       (tbl_we),
    .out_tbl_addr     (tbl_addr),
    .out_tbl_wdata    (tbl_wdata),
    .in_tbl_rdata     (tbl_rdata),
    .out_init_busy    (init_busy),
    .out_perf_lookups (perf_lookups),
    .out_perf_updates (perf_updates),
    .out_perf_stalls  (perf_stalls)
  );

  // Behavioural single-port SRAM, read data valid the cycle after the read.
  logic [1:0] mem [N];
  initial begin
    for (int i = 0; i < N; i++) mem[i] = 2'b10;
    tbl_rdata = 2'b00;
  end
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic [1:0] ctr;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [1:0] model [N];

  function automatic logic [1:0] train(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected lookup, one cycle after accept.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: actual=%0h required=none (cycle %0d)", resp_ctr, cycle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_ctr", 32'(resp_ctr), 32'(e.ctr));
        check("resp_latency", 32'(cycle), 32'(e.cyc + 1));
      end
    end
  end

  task automatic do_lookup(input logic [IDX_W-1:0] idx, output int waited);
    bit done = 0;
    waited = 0;
    lookup_valid = 1'b1;
    lookup_idx   = idx;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (lookup_rdy === 1'b1) begin
        exp_q.push_back('{ctr: model[idx], cyc: cycle});
        done = 1;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    if (!done) check("lookup_timeout", 32'(waited), 32'(0));
    @(posedge clk); #1;
    lookup_valid = 1'b0;
  endtask

  task automatic do_update(input logic [IDX_W-1:0] idx, input logic taken);
    bit done = 0;
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = taken;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (upd_rdy === 1'b1) begin
        model[idx] = train(model[idx], taken);
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) check("update_timeout", 32'(BOUND), 32'(0));
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for n cycles with a lookup held, then watch the sweep refuse it for 16 cycles.
  task automatic apply_reset(input int unsigned n);
    int k = 0;
    rst_n        = 1'b0;
    lookup_valid = 1'b1;
    lookup_idx   = '0;
    upd_valid    = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) begin
        check("rst_tbl_en", 32'(tbl_en), 32'(0));
        check("rst_tbl_we", 32'(tbl_we), 32'(0));
        check("rst_lookup_rdy", 32'(lookup_rdy), 32'(0));
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) model[i] = 2'b01;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (init_busy !== 1'b1) begin
        lookup_valid = 1'b0;
        break;
      end
      if (k == 0) begin
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_resp_ctr", 32'(resp_ctr), 32'(0));
        check("rst_upd_rdy", 32'(upd_rdy), 32'(1));
      end
      check("init_write", {tbl_en, tbl_we, 2'(tbl_wdata), 28'(tbl_addr)}, {1'b1, 1'b1, 2'b01, 28'(k)});
      check("init_lookup_rdy", 32'(lookup_rdy), 32'(0));
      k++;
    end
    check("init_cycles", 32'(k), 32'(N));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n        = 1'b0;
    lookup_valid = 1'b0;
    lookup_idx   = '0;
    upd_valid    = 1'b0;
    upd_idx      = '0;
    upd_taken    = 1'b0;

    apply_reset(3);

    // Lookup right after init is accepted the same cycle.
    do_lookup(4'd5, w);
    check("lookup5_wait", 32'(w), 32'(0));
    for (int i = 0; i < N; i++) do_lookup(4'(i), w);
    idle_cycles(3);
    check("resp_ctr_hold", 32'(resp_ctr), 32'(model[N-1]));

    // Saturation on one counter, back-to-back updates accumulate.
    for (int i = 0; i < 3; i++) do_update(4'd3, 1'b1);
    idle_cycles(DRAIN);
    do_lookup(4'd3, w);
    do_update(4'd3, 1'b1);
    idle_cycles(DRAIN);
    do_lookup(4'd3, w);
    for (int i = 0; i < 4; i++) do_update(4'd3, 1'b0);
    idle_cycles(DRAIN);
    do_lookup(4'd3, w);

    // Fill the FIFO while lookups are held: full forces a drain slot.
    lookup_valid = 1'b1;
    lookup_idx   = 4'd15;
    for (int i = 0; i < FIFO_D; i++) begin
      upd_valid = 1'b1;
      upd_idx   = 4'(8 + i);
      upd_taken = 1'($urandom_range(1));
      @(negedge clk);
      check("fill_upd_rdy_open", 32'(upd_rdy), 32'(1));
      check("fill_lookup_rdy_open", 32'(lookup_rdy), 32'(1));
      if (lookup_rdy === 1'b1) exp_q.push_back('{ctr: model[15], cyc: cycle});
      if (upd_rdy === 1'b1) model[8 + i] = train(model[8 + i], upd_taken);
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    @(negedge clk);
    check("full_upd_rdy", 32'(upd_rdy), 32'(0));
    check("full_lookup_rdy", 32'(lookup_rdy), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("updwr_lookup_rdy", 32'(lookup_rdy), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("lookup_resume", 32'(lookup_rdy), 32'(1));
    if (lookup_rdy === 1'b1) exp_q.push_back('{ctr: model[15], cyc: cycle});
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    idle_cycles(DRAIN);
    for (int i = 8; i < 12; i++) do_lookup(4'(i), w);

    // Randomised batches: updates then drained lookups against the model.
    for (int r = 0; r < 20; r++) begin
      int nu = $urandom_range(6, 1);
      int nl = $urandom_range(5, 1);
      for (int i = 0; i < nu; i++) do_update(4'($urandom_range(N - 1)), 1'($urandom_range(1)));
      idle_cycles(DRAIN);
      for (int i = 0; i < nl; i++) do_lookup(4'($urandom_range(N - 1)), w);
    end

    // Reset with two updates queued behind held lookups.
    lookup_valid = 1'b1;
    lookup_idx   = 4'd0;
    for (int i = 0; i < 2; i++) begin
      upd_valid = 1'b1;
      upd_idx   = 4'd7;
      upd_taken = 1'b1;
      @(negedge clk);
      check("q_upd_rdy", 32'(upd_rdy), 32'(1));
      if (lookup_rdy === 1'b1) exp_q.push_back('{ctr: model[0], cyc: cycle});
      @(posedge clk); #1;
    end
    apply_reset(1);

    // Counter scenario: 10 lookups, 3 updates, 2 stall cycles.
    do_lookup(4'd7, w);
    for (int i = 1; i < 8; i++) do_lookup(4'(i), w);
    for (int j = 0; j < 2; j++) begin
      do_update(4'(12 + j), 1'b1);
      idle_cycles(1);
      do_lookup(4'(12 + j), w);
    end
    do_update(4'd14, 1'b0);
    idle_cycles(DRAIN);
`ifdef BPU_PERF_CNT_EN
    check("perf_lookups", perf_lookups, 32'd10);
    check("perf_updates", perf_updates, 32'd3);
    check("perf_stalls", perf_stalls, 32'd2);
`else
    check("perf_lookups", perf_lookups, 32'd0);
    check("perf_updates", perf_updates, 32'd0);
    check("perf_stalls", perf_stalls, 32'd0);
`endif
    do_lookup(4'd14, w);
    idle_cycles(4);
    check("pending_resps", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
